// File: rtl/fp_div_seq.sv
`default_nettype none
// ============================================================================
// Module      : fp_div_seq
// Description : Sequential floating-point divider, bfloat16 layout by default.
//               Restoring significand division, one quotient bit per cycle,
//               followed by normalise and round-to-nearest-even steps.
//               Subnormal inputs are read as zero and subnormal results
//               flush to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_div_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 7
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [EXP_W+MAN_W:0]   opA,
  input  logic [EXP_W+MAN_W:0]   opB,
  output logic [EXP_W+MAN_W:0]   quotient,
  output logic                   valid,
  output logic                   busy,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   inexact,
  output logic                   dbz,
  output logic                   invalid
);

  localparam int c_W  = 1 + EXP_W + MAN_W;
  localparam int c_XW = EXP_W + 2;          // two's-complement exponent width
  localparam int c_QW = MAN_W + 3;          // raw quotient bits
  localparam int c_RW = MAN_W + 3;          // partial remainder width
  localparam int c_CW = $clog2(c_QW + 1);
  localparam logic [c_XW-1:0]  c_BIAS     = c_XW'((1 << (EXP_W - 1)) - 1);
  localparam logic [c_XW-1:0]  c_EMAX     = c_XW'((1 << EXP_W) - 1);
  localparam logic [EXP_W-1:0] c_EXP_ONES = '1;
  localparam logic [c_W-1:0]   c_QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_NORM, S_DONE} state_t;

  state_t            r_state;
  logic [c_CW-1:0]   r_cnt;
  logic [c_RW-1:0]   r_rem;
  logic [c_QW-1:0]   r_q;
  logic [MAN_W:0]    r_y;
  logic [c_XW-1:0]   r_exp;
  logic              r_sign;
  logic [MAN_W-1:0]  r_frac;
  logic              r_g;
  logic              r_s;
  logic              r_phase;      // NORM: 0 = normalise step, 1 = round/pack step
  logic              r_special;
  logic [c_W-1:0]    r_spec_q;
  logic              r_spec_dbz;
  logic              r_spec_inv;

  // Operand field decode
  logic [EXP_W-1:0]  w_a_exp, w_b_exp;
  logic [MAN_W-1:0]  w_a_frac, w_b_frac;
  logic              w_sign, w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
  logic [c_XW-1:0]   w_exp0;

  assign w_a_exp  = opA[MAN_W +: EXP_W];
  assign w_b_exp  = opB[MAN_W +: EXP_W];
  assign w_a_frac = opA[MAN_W-1:0];
  assign w_b_frac = opB[MAN_W-1:0];
  assign w_sign   = opA[c_W-1] ^ opB[c_W-1];
  assign w_a_nan  = (w_a_exp == c_EXP_ONES) && (w_a_frac != '0);
  assign w_b_nan  = (w_b_exp == c_EXP_ONES) && (w_b_frac != '0);
  assign w_a_inf  = (w_a_exp == c_EXP_ONES) && (w_a_frac == '0);
  assign w_b_inf  = (w_b_exp == c_EXP_ONES) && (w_b_frac == '0);
  assign w_a_zero = (w_a_exp == '0);
  assign w_b_zero = (w_b_exp == '0);
  assign w_exp0   = {2'b00, w_a_exp} - {2'b00, w_b_exp} + c_BIAS;

  logic              w_special, w_spec_dbz, w_spec_inv;
  logic [c_W-1:0]    w_spec_q;

  // Classify operand pairs that bypass the divider; NaN cases take priority
  always_comb begin
    w_special  = 1'b1;
    w_spec_q   = '0;
    w_spec_dbz = 1'b0;
    w_spec_inv = 1'b0;
    if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
      w_spec_q   = c_QNAN;
      w_spec_inv = 1'b1;
    end else if (w_a_inf) begin
      w_spec_q = {w_sign, c_EXP_ONES, {MAN_W{1'b0}}};
    end else if (w_b_inf) begin
      w_spec_q = {w_sign, {(c_W-1){1'b0}}};
    end else if (w_b_zero) begin
      w_spec_q   = {w_sign, c_EXP_ONES, {MAN_W{1'b0}}};
      w_spec_dbz = 1'b1;
    end else if (w_a_zero) begin
      w_spec_q = {w_sign, {(c_W-1){1'b0}}};
    end else begin
      w_special = 1'b0;
    end
  end

  // One restoring-division step
  logic [c_RW-1:0]   w_y_ext, w_sub;
  logic              w_ge;
  assign w_y_ext = c_RW'(r_y);
  assign w_ge    = (r_rem >= w_y_ext);
  assign w_sub   = w_ge ? (r_rem - w_y_ext) : r_rem;

  logic [MAN_W-1:0]  w_n_frac;
  logic              w_n_g, w_n_s;
  logic [c_XW-1:0]   w_n_exp;

  // Normalise: a quotient below 1.0 loses one exponent and shifts left by one
  always_comb begin
    w_n_frac = r_q[MAN_W+1:2];
    w_n_g    = r_q[1];
    w_n_s    = r_q[0] | (r_rem != '0);
    w_n_exp  = r_exp;
    if (!r_q[c_QW-1]) begin
      w_n_frac = r_q[MAN_W:1];
      w_n_g    = r_q[0];
      w_n_s    = (r_rem != '0);
      w_n_exp  = r_exp - c_XW'(1);
    end
  end

  // Round to nearest even; a carry out of the fraction bumps the exponent
  logic              w_inc, w_ovf, w_unf;
  logic [MAN_W:0]    w_frac_sum;
  logic [MAN_W-1:0]  w_frac_rnd;
  logic [c_XW-1:0]   w_exp_rnd;
  assign w_inc      = r_g & (r_s | r_frac[0]);
  assign w_frac_sum = {1'b0, r_frac} + (MAN_W+1)'(w_inc);
  assign w_frac_rnd = w_frac_sum[MAN_W-1:0];
  assign w_exp_rnd  = r_exp + c_XW'(w_frac_sum[MAN_W]);
  assign w_ovf      = !w_exp_rnd[c_XW-1] && (w_exp_rnd >= c_EMAX);
  assign w_unf      = w_exp_rnd[c_XW-1] || (w_exp_rnd == '0);

  // Control FSM with datapath registers and registered result/flags
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_rem      <= '0;
      r_q        <= '0;
      r_y        <= '0;
      r_exp      <= '0;
      r_sign     <= 1'b0;
      r_frac     <= '0;
      r_g        <= 1'b0;
      r_s        <= 1'b0;
      r_phase    <= 1'b0;
      r_special  <= 1'b0;
      r_spec_q   <= '0;
      r_spec_dbz <= 1'b0;
      r_spec_inv <= 1'b0;
      quotient   <= '0;
      valid      <= 1'b0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      inexact    <= 1'b0;
      dbz        <= 1'b0;
      invalid    <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            busy       <= 1'b1;
            r_sign     <= w_sign;
            r_y        <= {1'b1, w_b_frac};
            r_rem      <= c_RW'({1'b1, w_a_frac});
            r_q        <= '0;
            r_exp      <= w_exp0;
            r_cnt      <= '0;
            r_special  <= w_special;
            r_spec_q   <= w_spec_q;
            r_spec_dbz <= w_spec_dbz;
            r_spec_inv <= w_spec_inv;
            if (w_special) begin
              r_state <= S_NORM;
              r_phase <= 1'b1;
            end else begin
              r_state <= S_DIV;
              r_phase <= 1'b0;
            end
          end
        end
        S_DIV: begin
          r_rem <= c_RW'({w_sub, 1'b0});
          r_q   <= {r_q[c_QW-2:0], w_ge};
          r_cnt <= r_cnt + c_CW'(1);
          if (r_cnt == c_CW'(c_QW - 1)) r_state <= S_NORM;
        end
        S_NORM: begin
          if (!r_phase) begin
            r_frac  <= w_n_frac;
            r_g     <= w_n_g;
            r_s     <= w_n_s;
            r_exp   <= w_n_exp;
            r_phase <= 1'b1;
          end else begin
            r_state   <= S_DONE;
            valid     <= 1'b1;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            inexact   <= 1'b0;
            dbz       <= 1'b0;
            invalid   <= 1'b0;
            if (r_special) begin
              quotient <= r_spec_q;
              dbz      <= r_spec_dbz;
              invalid  <= r_spec_inv;
            end else if (w_ovf) begin
              quotient <= {r_sign, c_EXP_ONES, {MAN_W{1'b0}}};
              overflow <= 1'b1;
              inexact  <= 1'b1;
            end else if (w_unf) begin
              quotient  <= {r_sign, {(c_W-1){1'b0}}};
              underflow <= 1'b1;
              inexact   <= 1'b1;
            end else begin
              quotient <= {r_sign, w_exp_rnd[EXP_W-1:0], w_frac_rnd};
              inexact  <= r_g | r_s;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
